// File: rtl/mips_decode_stage_if.sv
// Handshake and decoded-payload bundle for the MIPS decode stage.
// The slave side is the stage itself; the master side is upstream/downstream logic.
interface mips_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_op;
  logic [2:0]  out_class;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_dst;
  logic [4:0]  out_shamt;
  logic [15:0] out_imm;
  logic [25:0] out_jidx;
  logic [1:0]  out_tuse_rs;
  logic [1:0]  out_tuse_rt;
  logic [1:0]  out_tnew;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_op, out_class, out_rs, out_rt,
           out_rd, out_dst, out_shamt, out_imm, out_jidx, out_tuse_rs,
           out_tuse_rt, out_tnew, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_op, out_class, out_rs, out_rt,
           out_rd, out_dst, out_shamt, out_imm, out_jidx, out_tuse_rs,
           out_tuse_rt, out_tnew, out_illegal
  );
endinterface

// File: rtl/mips_decode_stage.sv
// Registered MIPS decode stage: opcode/class/field decode with hazard metadata,
// valid/ready output register with flush, and saturating per-class retire counters.
module mips_decode_stage #(
  parameter bit          EXT_EN = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  mips_decode_stage_if.slave bus,
  input  logic             cnt_clr,
  input  logic [2:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_value
);

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,  OP_ADDU  = 5'd1,  OP_SUBU  = 5'd2,  OP_ADD   = 5'd3,
    OP_SUB   = 5'd4,  OP_AND   = 5'd5,  OP_OR    = 5'd6,  OP_XOR   = 5'd7,
    OP_SLL   = 5'd8,  OP_SRL   = 5'd9,  OP_ORI   = 5'd10, OP_LW    = 5'd11,
    OP_SW    = 5'd12, OP_LUI   = 5'd13, OP_ADDI  = 5'd14, OP_ADDIU = 5'd15,
    OP_BEQ   = 5'd16, OP_BNE   = 5'd17, OP_J     = 5'd18, OP_JAL   = 5'd19,
    OP_JR    = 5'd20, OP_SLT   = 5'd21, OP_SLTU  = 5'd22, OP_ANDI  = 5'd23,
    OP_XORI  = 5'd24, OP_ILL   = 5'd31
  } op_e;

  typedef enum logic [2:0] {
    CL_R = 3'd0, CL_I = 3'd1, CL_B = 3'd2, CL_L = 3'd3,
    CL_S = 3'd4, CL_J = 3'd5, CL_ILL = 3'd7
  } class_e;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  logic [5:0] opc;
  logic [5:0] funct;
  logic [4:0] f_rs, f_rt, f_rd;

  assign opc   = bus.in_instr[31:26];
  assign funct = bus.in_instr[5:0];
  assign f_rs  = bus.in_instr[25:21];
  assign f_rt  = bus.in_instr[20:16];
  assign f_rd  = bus.in_instr[15:11];

  op_e        d_op;
  class_e     d_class;
  logic [4:0] d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;

  always_comb begin
    d_op = OP_ILL;
    case (opc)
      6'b000000: begin
        case (funct)
          6'b100001: d_op = OP_ADDU;
          6'b100011: d_op = OP_SUBU;
          6'b100000: d_op = OP_ADD;
          6'b100010: d_op = OP_SUB;
          6'b100100: d_op = OP_AND;
          6'b100101: d_op = OP_OR;
          6'b100110: d_op = OP_XOR;
          6'b000000: d_op = (bus.in_instr == '0) ? OP_NOP : OP_SLL;
          6'b000010: d_op = OP_SRL;
          6'b001000: d_op = OP_JR;
          6'b101010: d_op = EXT_EN ? OP_SLT  : OP_ILL;
          6'b101011: d_op = EXT_EN ? OP_SLTU : OP_ILL;
          default:   d_op = OP_ILL;
        endcase
      end
      6'b001101: d_op = OP_ORI;
      6'b100011: d_op = OP_LW;
      6'b101011: d_op = OP_SW;
      6'b001111: d_op = OP_LUI;
      6'b001000: d_op = OP_ADDI;
      6'b001001: d_op = OP_ADDIU;
      6'b000100: d_op = OP_BEQ;
      6'b000101: d_op = OP_BNE;
      6'b000010: d_op = OP_J;
      6'b000011: d_op = OP_JAL;
      6'b001100: d_op = EXT_EN ? OP_ANDI : OP_ILL;
      6'b001110: d_op = EXT_EN ? OP_XORI : OP_ILL;
      default:   d_op = OP_ILL;
    endcase
  end

  // Class, destination and hazard timing all follow from the decoded opcode.
  always_comb begin
    d_class   = CL_ILL;
    d_dst     = '0;
    d_tuse_rs = TUSE_NONE;
    d_tuse_rt = TUSE_NONE;
    d_tnew    = 2'd0;
    case (d_op)
      OP_NOP: d_class = CL_R;
      OP_ADDU, OP_SUBU, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU: begin
        d_class   = CL_R;
        d_dst     = f_rd;
        d_tuse_rs = 2'd1;
        d_tuse_rt = 2'd1;
        d_tnew    = 2'd1;
      end
      OP_SLL, OP_SRL: begin
        d_class   = CL_R;
        d_dst     = f_rd;
        d_tuse_rt = 2'd1;
        d_tnew    = 2'd1;
      end
      OP_ORI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_XORI: begin
        d_class   = CL_I;
        d_dst     = f_rt;
        d_tuse_rs = 2'd1;
        d_tnew    = 2'd1;
      end
      OP_LUI: begin
        d_class = CL_I;
        d_dst   = f_rt;
        d_tnew  = 2'd1;
      end
      OP_LW: begin
        d_class   = CL_L;
        d_dst     = f_rt;
        d_tuse_rs = 2'd1;
        d_tnew    = 2'd2;
      end
      OP_SW: begin
        d_class   = CL_S;
        d_tuse_rs = 2'd1;
        d_tuse_rt = 2'd2;
      end
      OP_BEQ, OP_BNE: begin
        d_class   = CL_B;
        d_tuse_rs = 2'd0;
        d_tuse_rt = 2'd0;
      end
      OP_J:  d_class = CL_J;
      OP_JAL: begin
        d_class = CL_J;
        d_dst   = 5'd31;
      end
      OP_JR: begin
        d_class   = CL_J;
        d_tuse_rs = 2'd0;
      end
      default: d_class = CL_ILL;
    endcase
  end

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [4:0]  op_q;
  logic [2:0]  class_q;
  logic [4:0]  dst_q;
  logic [1:0]  tuse_rs_q, tuse_rt_q, tnew_q;

  logic accept;
  logic retire;

  assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign retire       = valid_q && bus.out_ready && !bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      op_q      <= '0;
      class_q   <= '0;
      dst_q     <= '0;
      tuse_rs_q <= '0;
      tuse_rt_q <= '0;
      tnew_q    <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      pc_q      <= bus.in_pc;
      instr_q   <= bus.in_instr;
      op_q      <= d_op;
      class_q   <= d_class;
      dst_q     <= d_dst;
      tuse_rs_q <= d_tuse_rs;
      tuse_rt_q <= d_tuse_rt;
      tnew_q    <= d_tnew;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_op      = op_q;
  assign bus.out_class   = class_q;
  assign bus.out_rs      = instr_q[25:21];
  assign bus.out_rt      = instr_q[20:16];
  assign bus.out_rd      = instr_q[15:11];
  assign bus.out_shamt   = instr_q[10:6];
  assign bus.out_imm     = instr_q[15:0];
  assign bus.out_jidx    = instr_q[25:0];
  assign bus.out_dst     = dst_q;
  assign bus.out_tuse_rs = tuse_rs_q;
  assign bus.out_tuse_rt = tuse_rt_q;
  assign bus.out_tnew    = tnew_q;
  assign bus.out_illegal = (op_q == OP_ILL);

  // Counter slots 0..5 are the legal classes; slot 6 holds illegal (class/select 7).
  logic [CNT_W-1:0] cnt_q [7];
  logic [2:0]       ret_idx;
  logic [2:0]       rd_idx;

  assign ret_idx = (class_q == CL_ILL) ? 3'd6 : class_q;
  assign rd_idx  = (cnt_sel == 3'd7) ? 3'd6 : cnt_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 7; i++) cnt_q[i] <= '0;
    end else if (cnt_clr) begin
      for (int unsigned i = 0; i < 7; i++) cnt_q[i] <= '0;
    end else if (retire) begin
      for (int unsigned i = 0; i < 7; i++) begin
        if (3'(i) == ret_idx && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_value = '0;
    if (cnt_sel != 3'd6) begin
      for (int unsigned i = 0; i < 7; i++) begin
        if (3'(i) == rd_idx) cnt_value = cnt_q[i];
      end
    end
  end

endmodule

// File: doc/mips_decode_stage.md
# mips_decode_stage

Registered MIPS instruction-decode stage for the five-stage pipeline. It sits between the IF/ID instruction register and the hazard unit / ID/EX register. It decodes one 32-bit instruction per accepted transfer into an opcode enum, an instruction class, register fields and Tuse/Tnew hazard metadata, all held in an output register under a valid/ready handshake with flush. It extends the flat combinational decoder with an optional extended-ISA mode, illegal-opcode detection and saturating per-class retire counters.

## Interface
- `EXT_EN`, 0: 1 enables SLT, SLTU, ANDI, XORI; 0 decodes them as illegal.
- `CNT_W`, 16: width of each per-class counter, 4..32.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_instr`/`in_pc` valid.
- `in_ready` out 1: stage can accept this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in 32: PC of instruction.
- `flush` in 1: synchronous kill of held and incoming instruction.
- `out_valid` out 1: decoded payload valid.
- `out_ready` in 1: downstream accepts payload.
- `out_pc` out 32, `out_op` out 5, `out_class` out 3, `out_rs`/`out_rt`/`out_rd`/`out_dst`/`out_shamt` out 5 each, `out_imm` out 16, `out_jidx` out 26, `out_tuse_rs`/`out_tuse_rt`/`out_tnew` out 2 each, `out_illegal` out 1.
- `cnt_clr` in 1: synchronous clear of all counters.
- `cnt_sel` in 3: counter select (class code).
- `cnt_value` out CNT_W: combinational read of selected counter; sel 6 reads 0.

## Operation
- Opcode enum `out_op`: 0 NOP (word 0x00000000), 1 ADDU, 2 SUBU, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 SLL (nonzero word), 9 SRL, 10 ORI, 11 LW, 12 SW, 13 LUI, 14 ADDI, 15 ADDIU, 16 BEQ, 17 BNE, 18 J, 19 JAL, 20 JR, 21 SLT (func 101010), 22 SLTU (101011), 23 ANDI (op 001100), 24 XORI (op 001110), 31 illegal. Standard MIPS-I op/func encodings.
- Classes `out_class`: 0 R (op 000000, not JR), 1 I (ORI/LUI/ADDI/ADDIU/ANDI/XORI), 2 B, 3 L, 4 S, 5 J (J/JAL/JR), 7 illegal. NOP is class 0.
- `out_illegal` = 1 iff op 31, including 21..24 when EXT_EN=0. Payload fields still carry raw fields.
- Raw fields: rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], imm=[15:0], jidx=[25:0].
- `out_dst`: rd for class-0 ops except NOP, rt for I and LW, 31 for JAL, else 0.
- Tuse (3 = unused). rs: 0 for BEQ/BNE/JR, 1 for R ALU (not shifts), I except LUI, LW, SW; else 3. rt: 0 for BEQ/BNE, 1 for R ALU and shifts, 2 for SW; else 3.
- Tnew: 2 for LW, 1 for R ALU, shifts and I, 0 otherwise.
- `in_ready` = !flush && (!out_valid || out_ready).
- Accept when `in_valid && in_ready`: next cycle out_valid=1 with decoded payload.
- Payload and `out_valid` hold stable while `out_valid && !out_ready`.
- Retire when `out_valid && out_ready && !flush`: increments the counter for `out_class` (0..5, 7→index 6 unused, illegal counted at sel 7). Counters saturate at all-ones.
- `cnt_clr` has priority over a same-cycle increment.

## Timing
- Decode-to-output latency: 1 cycle. Throughput: 1 per cycle with out_ready held high.
- Flush: next cycle out_valid=0; the held payload is not retired. No input is accepted in the flush cycle.
- Retire and accept in the same cycle: new payload replaces old with no bubble.
- Reset (any time, mid-transfer included): out_valid=0, all payload outputs 0, counters 0. `in_ready` is 1 once reset is released.
- Counter read via `cnt_value` reflects the registered count. An increment appears the cycle after retire.

## Test plan
- Reset, then feed 0x012A4021 (addu $8,$9,$10) with out_ready=1: next cycle op=1, class=0, dst=8, tuse_rs=1, tuse_rt=1, tnew=1. cnt_value(sel 0)=1 the following cycle.
- 0x8D090004 (lw $9,4($8)) then 0x0C000010 (jal): op=11, dst=9, tnew=2, then op=19, dst=31, jidx=0x10, class=5.
- EXT_EN=0 vs 1 with 0x012A402A (slt): illegal=1/op=31/class=7 vs op=21/class=0.
- Stall: hold out_ready=0 three cycles with in_valid=1. Payload holds, in_ready=0, no counter change. Then release: one retire and the next accept in the same cycle.
- Flush while out_valid=1 and in_valid=1: out_valid=0 next cycle, input not taken, counters unchanged.
- CNT_W=4: retire 20 NOPs, then cnt_value=15. Assert cnt_clr in a retire cycle: value 0.
